piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out serializer with a valid/ready load handshake and a stall control. It accepts a WIDTH-bit word and shifts it out one bit per enabled clock, with a valid qualifier and first-bit/last-bit strobes. It is the transmit-side counterpart to the team's serial-in/parallel-out shift register. Consecutive words stream with no idle cycle between them.

## Interface
Parameters:
- WIDTH, 4: word width in bits; legal values are 2 to 32.
- MSB_FIRST, 1: selects bit order. 1 sends din[WIDTH-1] first. 0 sends din[0] first.

Ports:
- clk  in  1: clock; all state changes on its rising edge.
- rst  in  1: reset; asynchronous, active-low.
- din  in  WIDTH: parallel word to send.
- din_valid  in  1: din holds a word to load.
- din_ready  out  1: serializer can accept a word this cycle.
- shift_en  in  1: bit-advance enable. When low, the serializer stalls and holds all state.
- sout  out  1: serial data bit.
- sout_valid  out  1: sout carries a frame bit this cycle.
- sof  out  1: sout is the first bit of a word.
- eof  out  1: sout is the last bit of a word.
- busy  out  1: a word is in flight (state SHIFT).

## Operation
- State registers:
  - state: IDLE or SHIFT.
  - shreg: WIDTH bits.
  - cnt: $clog2(WIDTH) bits, counts bits remaining minus 1.
  - first: flag marking the first bit of the current word.
- Reset (rst=0), immediate and asynchronous:
  - state=IDLE, shreg=0, cnt=0, first=0.
  - Outputs: sout=0, sout_valid=0, sof=0, eof=0, busy=0, din_ready=1.
- Accept condition: accept = din_valid & din_ready.
- din_ready is combinational: (state==IDLE) | (state==SHIFT & cnt==0 & shift_en).
- IDLE:
  - On accept: shreg<=din, cnt<=WIDTH-1, first<=1, state<=SHIFT.
  - Otherwise stay in IDLE.
  - shift_en is ignored in IDLE; loading does not require it.
- SHIFT:
  - Current bit: sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - sout_valid=1 and busy=1.
  - sof = first. eof = (cnt==0).
  - With shift_en=1 and cnt!=0:
    - shreg shifts toward the output end, filling with 0.
    - cnt<=cnt-1, first<=0.
  - With shift_en=1 and cnt==0:
    - On accept: reload exactly as from IDLE and stay in SHIFT (back-to-back).
    - Otherwise: state<=IDLE, shreg<=0.
  - With shift_en=0: all registers hold. The same bit stays on sout, and sof/eof are unchanged.
- Outputs decode from registered state only; there is no combinational path from din to sout.
- In IDLE: sout=0, sout_valid=0, sof=0, eof=0.
- din_valid while din_ready=0 has no effect. The source must hold din and din_valid until it is accepted.

## Timing
- Latency: a word accepted at edge N presents its first bit on sout after edge N, for the cycle N to N+1.
- Frame duration: WIDTH enabled cycles. With shift_en held at 1, that is exactly WIDTH clocks, one bit per clock.
- Back-to-back: with din_valid=1 in the eof cycle and shift_en=1, the next word's sof bit follows the previous eof bit with no gap. Sustained throughput is 1 bit per clock.
- Stall: each cycle with shift_en=0 extends the frame by one cycle. The bit, sof and eof repeat, and din_ready=0 unless the state is IDLE.
- Reset mid-frame: the frame is dropped with no residual bits. The first post-reset accept starts a fresh frame.
- WIDTH=2 boundary: sof is set on bit 0, and eof is set on bit 1 only.

## Test plan
- Basic frame. WIDTH=4, MSB_FIRST=1, shift_en=1, load din=4'b1011.
  - Required: sout=1,0,1,1 on the 4 cycles after the accept edge.
  - sof=1 on cycle 1 only; eof=1 on cycle 4 only; sout_valid=1 for exactly 4 cycles.
  - Then IDLE with din_ready=1.
- Bit order. MSB_FIRST=0, din=4'b1011.
  - Required: sout=1,1,0,1; sof/eof as in the basic frame.
- Back-to-back. Load 4'hA, then hold din=4'h5 with din_valid=1.
  - Required: 8 contiguous valid bits 1,0,1,0,0,1,0,1.
  - sof on bits 1 and 5; eof on bits 4 and 8; busy is never low in between.
- Stall. Load 4'b1100, and drive shift_en=0 for 3 cycles during the second bit.
  - Required: sout=1 for 1 cycle, then 1 for 4 cycles, then 0, 0.
  - Total 7 valid cycles; eof only on the final 0; din_ready=0 throughout the stall.
- Reset mid-frame. Assert rst=0 asynchronously (between clock edges) after 2 bits of 4'b1111.
  - Required: sout, sout_valid and busy go to 0 immediately, and din_ready goes to 1.
  - After release, loading 4'b0001 yields exactly 0,0,0,1.
- Handshake hold. Drive din_valid=1 with din=4'h3 during a stalled frame with cnt!=0.
  - Required: no accept and the current frame is unchanged.
  - The 4'h3 word is accepted only in the eof cycle with shift_en=1.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with load handshake and stall
// Shifts a WIDTH-bit word out one bit per enabled clock; reloads in the eof cycle for gapless streaming.

module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             first, first_n;
  logic             last;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      first <= first_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    first_n    = first;
    din_ready  = 1'b0;
    accept     = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    busy       = 1'b0;
    last       = (cnt == '0);

    case (state)
      IDLE: begin
        din_ready = 1'b1;
        accept    = din_valid;
        if (accept) begin
          shreg_n = din;
          cnt_n   = CW'(WIDTH - 1);
          first_n = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        sout_valid = 1'b1;
        busy       = 1'b1;
        sof        = first;
        eof        = last;
        din_ready  = last & shift_en;
        accept     = din_valid & din_ready;
        // A stalled cycle leaves every register untouched so the bit and strobes repeat.
        if (shift_en) begin
          if (!last) begin
            shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            cnt_n   = cnt - CW'(1);
            first_n = 1'b0;
          end else if (accept) begin
            shreg_n = din;
            cnt_n   = CW'(WIDTH - 1);
            first_n = 1'b1;
          end else begin
            state_n = IDLE;
            shreg_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
// Directed vector tables, hand-written reset sequence, and randomized traffic against a bit-index model.

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       shift_en = 1'b0;

  logic [2:0] din_ready, sout, sout_valid, sof, eof, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .shift_en(shift_en), .sout(sout[0]), .sout_valid(sout_valid[0]), .sof(sof[0]),
    .eof(eof[0]), .busy(busy[0])
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .shift_en(shift_en), .sout(sout[1]), .sout_valid(sout_valid[1]), .sof(sof[1]),
    .eof(eof[1]), .busy(busy[1])
  );

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_2 (
    .clk(clk), .rst(rst), .din(din[1:0]), .din_valid(din_valid), .din_ready(din_ready[2]),
    .shift_en(shift_en), .sout(sout[2]), .sout_valid(sout_valid[2]), .sof(sof[2]),
    .eof(eof[2]), .busy(busy[2])
  );

  typedef struct {
    logic [3:0] din;
    logic       dv, en;
    logic       so_m, so_l, sv, sf, ef, rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] d, logic dv, logic en, logic so_m, logic so_l,
                              logic sv, logic sf, logic ef, logic rdy);
    vec_t v;
    v.din = d; v.dv = dv; v.en = en; v.so_m = so_m; v.so_l = so_l;
    v.sv = sv; v.sf = sf; v.ef = ef; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: word plus bit position, per instance.
  int  m_w[3]   = '{4, 4, 2};
  bit  m_msb[3] = '{1'b1, 1'b0, 1'b1};
  bit  m_act[3];
  int  m_pos[3];
  int  m_word[3];

  function automatic logic m_rdy(int k);
    return !m_act[k] || (m_pos[k] == m_w[k] - 1 && shift_en);
  endfunction

  function automatic logic m_bit(int k);
    int idx;
    if (!m_act[k]) return 1'b0;
    idx = m_msb[k] ? (m_w[k] - 1 - m_pos[k]) : m_pos[k];
    return logic'((m_word[k] >> idx) & 1);
  endfunction

  task automatic m_step();
    for (int k = 0; k < 3; k++) begin
      logic acc;
      acc = din_valid && m_rdy(k);
      if (m_act[k] && shift_en) begin
        if (m_pos[k] < m_w[k] - 1) m_pos[k]++;
        else if (acc) begin m_word[k] = int'(din) & ((1 << m_w[k]) - 1); m_pos[k] = 0; end
        else m_act[k] = 1'b0;
      end else if (!m_act[k] && acc) begin
        m_act[k] = 1'b1; m_pos[k] = 0; m_word[k] = int'(din) & ((1 << m_w[k]) - 1);
      end
    end
  endtask

  initial begin
    // Basic frame 1011
    tbl.push_back(mk(4'hB,1,1, 0,0,0,0,0,1));
    tbl.push_back(mk(4'h0,0,1, 1,1,1,1,0,0));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,1,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,0,0,0,0,1));
    // Back-to-back A then 5
    tbl.push_back(mk(4'hA,1,1, 0,0,0,0,0,1));
    tbl.push_back(mk(4'h5,1,1, 1,0,1,1,0,0));
    tbl.push_back(mk(4'h5,1,1, 0,1,1,0,0,0));
    tbl.push_back(mk(4'h5,1,1, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h5,1,1, 0,1,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,1,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,0,0,0,0,1));
    // Stall on second bit of 1100
    tbl.push_back(mk(4'hC,1,1, 0,0,0,0,0,1));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,1,0,0));
    tbl.push_back(mk(4'h0,0,0, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,0, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,0, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,0,0,0,0,1));
    // Handshake hold: 3 offered during stalled 1001, taken only at eof
    tbl.push_back(mk(4'h9,1,1, 0,0,0,0,0,1));
    tbl.push_back(mk(4'h0,0,1, 1,1,1,1,0,0));
    tbl.push_back(mk(4'h3,1,0, 0,0,1,0,0,0));
    tbl.push_back(mk(4'h3,1,0, 0,0,1,0,0,0));
    tbl.push_back(mk(4'h3,1,1, 0,0,1,0,0,0));
    tbl.push_back(mk(4'h3,1,1, 0,0,1,0,0,0));
    tbl.push_back(mk(4'h3,1,1, 1,1,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,1,0,0));
    tbl.push_back(mk(4'h0,0,1, 0,1,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,0,0));
    tbl.push_back(mk(4'h0,0,1, 1,0,1,0,1,1));
    tbl.push_back(mk(4'h0,0,1, 0,0,0,0,0,1));

    // Reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset sout[%0d]", k), sout[k], 1'b0);
      chk($sformatf("reset sout_valid[%0d]", k), sout_valid[k], 1'b0);
      chk($sformatf("reset sof/eof[%0d]", k), sof[k] | eof[k], 1'b0);
      chk($sformatf("reset busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("reset din_ready[%0d]", k), din_ready[k], 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      din = tbl[i].din; din_valid = tbl[i].dv; shift_en = tbl[i].en;
      #1;
      chk($sformatf("vec%0d sout_m", i), sout[0], tbl[i].so_m);
      chk($sformatf("vec%0d sout_l", i), sout[1], tbl[i].so_l);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d sout_valid[%0d]", i, k), sout_valid[k], tbl[i].sv);
        chk($sformatf("vec%0d busy[%0d]", i, k), busy[k], tbl[i].sv);
        chk($sformatf("vec%0d sof[%0d]", i, k), sof[k], tbl[i].sf);
        chk($sformatf("vec%0d eof[%0d]", i, k), eof[k], tbl[i].ef);
        chk($sformatf("vec%0d din_ready[%0d]", i, k), din_ready[k], tbl[i].rdy);
      end
    end

    // Asynchronous reset after two bits of 1111
    @(negedge clk); din = 4'hF; din_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst sout[%0d]", k), sout[k], 1'b0);
      chk($sformatf("midrst sout_valid[%0d]", k), sout_valid[k], 1'b0);
      chk($sformatf("midrst busy[%0d]", k), busy[k], 1'b0);
      chk($sformatf("midrst din_ready[%0d]", k), din_ready[k], 1'b1);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); din = 4'h1; din_valid = 1'b1;
    begin
      logic [3:0] exp_m, exp_l;
      exp_m = 4'b0001;
      exp_l = 4'b1000;
      for (int b = 0; b < 5; b++) begin
        @(negedge clk); din_valid = 1'b0;
        #1;
        chk($sformatf("postrst sout_m b%0d", b), sout[0], (b < 4) ? exp_m[3-b] : 1'b0);
        chk($sformatf("postrst sout_l b%0d", b), sout[1], (b < 4) ? exp_l[3-b] : 1'b0);
        chk($sformatf("postrst sout_valid b%0d", b), sout_valid[0], b < 4);
        chk($sformatf("postrst sof b%0d", b), sof[0], b == 0);
        chk($sformatf("postrst eof b%0d", b), eof[0], b == 3);
      end
    end

    // Randomized traffic, all three instances against the model
    @(negedge clk); rst = 1'b0; din_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 3; k++) begin m_act[k] = 1'b0; m_pos[k] = 0; m_word[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      din       = 4'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      shift_en  = ($urandom_range(0, 4) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd c%0d sout[%0d]", c, k), sout[k], m_bit(k));
        chk($sformatf("rnd c%0d sout_valid[%0d]", c, k), sout_valid[k], m_act[k]);
        chk($sformatf("rnd c%0d busy[%0d]", c, k), busy[k], m_act[k]);
        chk($sformatf("rnd c%0d sof[%0d]", c, k), sof[k], m_act[k] && m_pos[k] == 0);
        chk($sformatf("rnd c%0d eof[%0d]", c, k), eof[k], m_act[k] && m_pos[k] == m_w[k] - 1);
        chk($sformatf("rnd c%0d din_ready[%0d]", c, k), din_ready[k], m_rdy(k));
      end
      @(posedge clk);
      m_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
